// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types for the instruction/LSU memory port arbiter.
//   arb_state_t : arbiter transaction phase (idle / request pending / response pending)
//   arb_owner_t : which requester a transaction belongs to
//   FETCH_BE    : byte enables driven for instruction fetches
// -----------------------------------------------------------------------------
package core_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_INSTR = 1'b0,
        REQ_DATA  = 1'b1
    } arb_owner_t;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_arb_prio.sv
// -----------------------------------------------------------------------------
// mem_arb_prio
// Winner selection for a new memory transaction. The LSU normally wins over
// instruction fetch. With ARB_STARVE_GUARD_EN defined, a counter tracks how
// many decisions in a row fetch lost to the LSU; once it reaches STARVE_LIMIT
// the next decision goes to fetch. Without the macro no counter exists.
// Ports:
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   instr_req_i     fetch request
//   data_req_i      LSU request
//   decide_i        an arbitration decision is being taken this cycle
//   instr_gnt_i     fetch is granted this cycle
//   winner_o        selected requester
// -----------------------------------------------------------------------------
module mem_arb_prio
    import core_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
)(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       instr_req_i,
    input  logic       data_req_i,
    input  logic       decide_i,
    input  logic       instr_gnt_i,
    output arb_owner_t winner_o
);

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned     CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             starved_s;

    assign starved_s = (cnt_q == LIMIT_C);

    // Data priority unless fetch has been starved for the full limit.
    always_comb begin
        if (data_req_i && !(instr_req_i && starved_s)) begin
            winner_o = REQ_DATA;
        end else begin
            winner_o = REQ_INSTR;
        end
    end

    // Count fetch losses in contested decisions; any fetch grant restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (instr_gnt_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (decide_i && instr_req_i && data_req_i && (winner_o == REQ_DATA)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_s;

    assign unused_s = ^{clk_i, rst_n_i, decide_i, instr_gnt_i, instr_req_i};
    assign winner_o = data_req_i ? REQ_DATA : REQ_INSTR;
`endif

endmodule

// File: rtl/mem_port_arbiter_chk.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_chk
// Protocol checks for mem_port_arbiter.
// Ports:
//   clk_i, rst_n_i   clock, asynchronous active-low reset
//   state_i, sel_i   arbiter phase and locked requester
//   instr_req_i, data_req_i, mem_rvalid_i  observed handshake inputs
// -----------------------------------------------------------------------------
module mem_port_arbiter_chk
    import core_pkg::*;
(
    input logic       clk_i,
    input logic       rst_n_i,
    input arb_state_t state_i,
    input arb_owner_t sel_i,
    input logic       instr_req_i,
    input logic       data_req_i,
    input logic       mem_rvalid_i
);

    // A requester locked in while waiting for the memory must not retract.
    a_req_held: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (state_i == ARB_REQ) |-> ((sel_i == REQ_INSTR) ? instr_req_i : data_req_i));

    // The memory may only respond while a transaction is outstanding.
    a_rvalid_in_resp: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        mem_rvalid_i |-> (state_i == ARB_RESP));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory (req/gnt/rvalid) between instruction fetch and
// the LSU with at most one outstanding transaction. Responses are routed to the
// requester that issued them; fetch responses made stale by flush_instr_i are
// dropped. Optional macro ARB_STARVE_GUARD_EN enables the fetch starve guard
// (see mem_arb_prio, limit STARVE_LIMIT).
// Ports:
//   clk_i, rst_n_i                      clock, asynchronous active-low reset
//   instr_req_i/addr_i, instr_gnt_o,
//   instr_rvalid_o/rdata_o              fetch port
//   data_req_i/addr_i/we_i/be_i/wdata_i,
//   data_gnt_o, data_rvalid_o/rdata_o   LSU port
//   flush_instr_i                       discard any in-flight fetch response
//   mem_req_o/addr_o/we_o/be_o/wdata_o,
//   mem_gnt_i, mem_rvalid_i/rdata_i     memory port
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8
)(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    input  logic        flush_instr_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    arb_owner_t sel_q, sel_d;
    arb_owner_t win_s;
    arb_owner_t cur_s;
    logic       drop_q, drop_d;
    logic       any_req_s;
    logic       decide_s;
    logic       mem_req_s;
    logic       rsp_s;

    assign any_req_s = instr_req_i | data_req_i;
    assign decide_s  = rst_n_i & (state_q == ARB_IDLE) & any_req_s;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .instr_req_i (instr_req_i),
        .data_req_i  (data_req_i),
        .decide_i    (decide_s),
        .instr_gnt_i (instr_gnt_o),
        .winner_o    (win_s)
    );

    // Next-state logic: arbitrate in IDLE, hold the locked choice in REQ, await the response in RESP.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        sel_d     = sel_q;
        cur_s     = sel_q;
        mem_req_s = 1'b0;
        rsp_s     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                cur_s = win_s;
                if (any_req_s) begin
                    mem_req_s = 1'b1;
                    if (mem_gnt_i) begin
                        owner_d = win_s;
                        state_d = ARB_RESP;
                    end else begin
                        sel_d   = win_s;
                        state_d = ARB_REQ;
                    end
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_REQ: begin
                mem_req_s = 1'b1;
                if (mem_gnt_i) begin
                    owner_d = sel_q;
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_REQ;
                end
            end
            ARB_RESP: begin
                if (mem_rvalid_i) begin
                    rsp_s   = 1'b1;
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_RESP;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of the clock.
    assign mem_req_o   = rst_n_i & mem_req_s;
    assign instr_gnt_o = mem_req_o & mem_gnt_i & (cur_s == REQ_INSTR);
    assign data_gnt_o  = mem_req_o & mem_gnt_i & (cur_s == REQ_DATA);

    // A flush arriving together with the response also kills it.
    assign instr_rvalid_o = rst_n_i & rsp_s & (owner_q == REQ_INSTR) & ~drop_q & ~flush_instr_i;
    assign data_rvalid_o  = rst_n_i & rsp_s & (owner_q == REQ_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    // Memory request fields from the current requester; fetches are full-word reads.
    always_comb begin
        mem_addr_o  = 32'h0000_0000;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = 32'h0000_0000;
        if (mem_req_o) begin
            if (cur_s == REQ_DATA) begin
                mem_addr_o  = data_addr_i;
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_addr_o  = instr_addr_i;
                mem_we_o    = 1'b0;
                mem_be_o    = FETCH_BE;
                mem_wdata_o = 32'h0000_0000;
            end
        end else begin
            mem_addr_o  = 32'h0000_0000;
        end
    end

    // Drop tracking: mark an in-flight or just-granted fetch stale, clear when its response is consumed.
    always_comb begin
        drop_d = drop_q;
        if (rsp_s) begin
            drop_d = 1'b0;
        end else if (flush_instr_i &&
                     (((state_q == ARB_RESP) && (owner_q == REQ_INSTR)) ||
                      ((state_q == ARB_REQ)  && (sel_q   == REQ_INSTR)) ||
                      instr_gnt_o)) begin
            drop_d = 1'b1;
        end else begin
            drop_d = drop_q;
        end
    end

    // State, ownership and drop registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            owner_q <= REQ_INSTR;
            sel_q   <= REQ_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            drop_q  <= drop_d;
        end
    end

    mem_port_arbiter_chk u_chk (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .state_i      (state_q),
        .sel_i        (sel_q),
        .instr_req_i  (instr_req_i),
        .data_req_i   (data_req_i),
        .mem_rvalid_i (mem_rvalid_i)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Randomized bench for mem_port_arbiter. The bench plays both requesters and
// the memory, and keeps a transaction-level reference: whether the single
// memory slot is free, being asked for, or waiting for data, who owns it,
// whether a fetch was flushed, and a reference copy of memory contents.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_LIMIT = 8;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        flush_instr_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .flush_instr_i(flush_instr_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state. Slot phase: 0 free, 1 asked but not granted, 2 granted awaiting data.
    int          ph;
    logic        own;        // 0 fetch, 1 LSU
    logic        drop;
    int          losses;
    logic [31:0] t_addr;
    logic        t_we;
    logic [31:0] ref_mem [16];
    // Memory-side view (what the memory itself latched from the DUT).
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [31:0] tb_mem [16];
    logic        clr_i, clr_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fetch_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    // Returns 1 when the LSU should win a fresh decision.
    function automatic logic pick_data(input logic ir, input logic dr, input int lost);
        logic starved;
`ifdef ARB_STARVE_GUARD_EN
        starved = (lost == int'(STARVE_LIMIT));
`else
        starved = (lost < 0);
`endif
        return dr && !(ir && starved);
    endfunction

    task automatic apply_clears();
        if (clr_i) instr_req_i = 1'b0;
        if (clr_d) data_req_i  = 1'b0;
        clr_i = 1'b0;
        clr_d = 1'b0;
    endtask

    task automatic new_requests();
        if (!instr_req_i && $urandom_range(0, 99) < 35) begin
            instr_req_i  = 1'b1;
            instr_addr_i = $urandom() & 32'h0000_0FFC;
        end
        if (!data_req_i && $urandom_range(0, 99) < 35) begin
            data_req_i   = 1'b1;
            data_addr_i  = 32'h0000_8000 | ($urandom() & 32'h0000_003C);
            data_we_i    = 1'($urandom_range(0, 1));
            data_be_i    = 4'($urandom_range(1, 15));
            data_wdata_i = $urandom();
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1 ns later, advance the reference.
    task automatic step();
        logic ereq, w, eig, edg, eirv, edrv;
        apply_clears();
        new_requests();
        flush_instr_i = ($urandom_range(0, 99) < 8);
        mem_gnt_i     = ($urandom_range(0, 99) < 60);
        mem_rvalid_i  = (ph == 2) && ($urandom_range(0, 99) < 50);
        if (mem_rvalid_i && !own)        mem_rdata_i = fetch_word(cap_addr);
        else if (mem_rvalid_i && !cap_we) mem_rdata_i = tb_mem[cap_addr[5:2]];
        else                              mem_rdata_i = $urandom();
        #1;
        ereq = 1'b0;
        w    = own;
        if (ph == 0 && (instr_req_i || data_req_i)) begin
            ereq = 1'b1;
            w    = pick_data(instr_req_i, data_req_i, losses);
        end else if (ph == 1) begin
            ereq = 1'b1;
        end
        eig  = ereq && mem_gnt_i && !w;
        edg  = ereq && mem_gnt_i && w;
        eirv = (ph == 2) && mem_rvalid_i && !own && !drop && !flush_instr_i;
        edrv = (ph == 2) && mem_rvalid_i && own;

        chk("mem_req", 32'(mem_req_o), 32'(ereq));
        if (ereq) begin
            chk("mem_addr",  mem_addr_o, w ? data_addr_i : instr_addr_i);
            chk("mem_we",    32'(mem_we_o), w ? 32'(data_we_i) : 32'h0);
            chk("mem_be",    32'(mem_be_o), w ? 32'(data_be_i) : 32'hF);
            chk("mem_wdata", mem_wdata_o, w ? data_wdata_i : 32'h0);
        end
        chk("instr_gnt",    32'(instr_gnt_o),    32'(eig));
        chk("data_gnt",     32'(data_gnt_o),     32'(edg));
        chk("instr_rvalid", 32'(instr_rvalid_o), 32'(eirv));
        chk("data_rvalid",  32'(data_rvalid_o),  32'(edrv));
        chk("instr_rdata_pass", instr_rdata_o, mem_rdata_i);
        chk("data_rdata_pass",  data_rdata_o,  mem_rdata_i);
        if (eirv)          chk("fetch_data", instr_rdata_o, fetch_word(t_addr));
        if (edrv && !t_we) chk("load_data",  data_rdata_o,  ref_mem[t_addr[5:2]]);

        if (ph == 0 && ereq && instr_req_i && data_req_i && w) losses++;
        if (eig) losses = 0;
        if (ph == 2 && mem_rvalid_i)                         drop = 1'b0;
        else if (flush_instr_i && ((ph != 0 && !own) || eig)) drop = 1'b1;

        if (ph == 2) begin
            if (mem_rvalid_i) ph = 0;
        end else if (ereq) begin
            own = w;
            if (mem_gnt_i) begin
                ph     = 2;
                t_addr = w ? data_addr_i : instr_addr_i;
                t_we   = w && data_we_i;
                if (t_we) ref_mem[t_addr[5:2]] = merge(ref_mem[t_addr[5:2]], data_wdata_i, data_be_i);
                cap_addr = mem_addr_o;
                cap_we   = mem_we_o;
                if (mem_we_o) tb_mem[mem_addr_o[5:2]] = merge(tb_mem[mem_addr_o[5:2]], mem_wdata_o, mem_be_o);
                if (w) clr_d = 1'b1;
                else   clr_i = 1'b1;
            end else begin
                ph = 1;
            end
        end
    endtask

    task automatic reset_model();
        ph     = 0;
        own    = 1'b0;
        drop   = 1'b0;
        losses = 0;
        t_we   = 1'b0;
        cap_we = 1'b0;
    endtask

    task automatic check_outputs_low(input string where);
        chk({where, "_mem_req"},      32'(mem_req_o),      32'h0);
        chk({where, "_instr_gnt"},    32'(instr_gnt_o),    32'h0);
        chk({where, "_data_gnt"},     32'(data_gnt_o),     32'h0);
        chk({where, "_instr_rvalid"}, 32'(instr_rvalid_o), 32'h0);
        chk({where, "_data_rvalid"},  32'(data_rvalid_o),  32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 32'h0;
            tb_mem[i]  = 32'h0;
        end
        clr_i = 1'b0;
        clr_d = 1'b0;
        reset_model();
        // Both requesters already waiting while reset is held.
        rst_n_i       = 1'b0;
        instr_req_i   = 1'b1;
        instr_addr_i  = 32'h0000_0100;
        data_req_i    = 1'b1;
        data_addr_i   = 32'h0000_8000;
        data_we_i     = 1'b1;
        data_be_i     = 4'h3;
        data_wdata_i  = 32'hCAFE_BEEF;
        flush_instr_i = 1'b0;
        mem_gnt_i     = 1'b1;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = 32'h0;
        #2;
        check_outputs_low("reset");
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            step();
        end

        // Reset while a response is outstanding; the response is lost.
        for (int k = 0; k < 200 && ph != 2; k++) begin
            @(negedge clk_i);
            step();
        end
        chk("reach_resp_phase", 32'(ph), 32'd2);
        @(negedge clk_i);
        apply_clears();
        rst_n_i       = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_gnt_i     = 1'b1;
        flush_instr_i = 1'b0;
        if (!instr_req_i) begin
            instr_req_i  = 1'b1;
            instr_addr_i = 32'h0000_0200;
        end
        #1;
        check_outputs_low("midreset");
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        reset_model();
        step();

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_i);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
